// File: rtl/sseg_pkg.sv
// Shared constants and types for the multiplexed seven-segment scan decoder:
// segment patterns, state encoding, and anode-select helpers.
package sseg_pkg;

    localparam logic [6:0] BLANK = 7'h7F;

    // Active-low patterns indexed by the hex value they display.
    localparam logic [6:0] SEG_PATTERN [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef enum logic [1:0] {SCAN, SETTLE, HOLD} state_t;

    typedef struct packed {
        logic [7:0] an;
        logic       dp;
        logic [6:0] seg;
    } sample_t;

    function automatic logic an_is_select(input logic [7:0] an);
        return (an[7:4] == 4'hF) && (an[3:0] inside {4'hE, 4'hD, 4'hB, 4'h7});
    endfunction

    function automatic logic [1:0] an_index(input logic [7:0] an);
        if (!an[0])      return 2'd0;
        else if (!an[1]) return 2'd1;
        else if (!an[2]) return 2'd2;
        else             return 2'd3;
    endfunction

endpackage

// File: rtl/sseg_scan_decoder_if.sv
// Display-side signals observed by the decoder and the decoded frame it reports.
interface sseg_scan_decoder_if;
    logic [6:0] sseg;
    logic       dp;
    logic [7:0] AN;
    logic [3:0] digit0;
    logic [3:0] digit1;
    logic [3:0] digit2;
    logic [3:0] digit3;
    logic [3:0] dp_out;
    logic       frame_valid;
    logic       seg_err;
    logic       stale;

    modport master (
        output sseg, dp, AN,
        input  digit0, digit1, digit2, digit3, dp_out, frame_valid, seg_err, stale
    );

    modport slave (
        input  sseg, dp, AN,
        output digit0, digit1, digit2, digit3, dp_out, frame_valid, seg_err, stale
    );
endinterface

// File: rtl/sseg_pattern_decode.sv
// Maps an active-low seven-segment pattern to its hex value; anything not in
// the table (including blank) is flagged invalid.
module sseg_pattern_decode
    import sseg_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] value,
    output logic       valid
);

    always_comb begin
        value = '0;
        valid = 1'b0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (pattern == SEG_PATTERN[i]) begin
                value = 4'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sseg_scan_decoder.sv
// Snoops a multiplexed 4-digit seven-segment display, debounces each anode
// dwell and publishes complete frames of hex digits and decimal points.
module sseg_scan_decoder
    import sseg_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 2**20
) (
    input  logic clk,
    input  logic reset,
    sseg_scan_decoder_if.slave bus
);

    localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    sample_t           smp, cmp;
    state_t            state, state_nx;
    logic [CW-1:0]     cnt, cnt_nx, cnt_inc;
    logic              load_cmp, capture, rescan;
    logic [TW-1:0]     tcnt;
    logic [3:0]        dec_value;
    logic              dec_valid;
    logic [1:0]        cap_idx;
    logic [3:0][3:0]   shadow, shadow_nx, digit_q;
    logic [3:0]        shadow_dp, shadow_dp_nx, dp_q;
    logic [3:0]        seen, seen_nx;
    logic              frame_valid_q, seg_err_q;

    sseg_pattern_decode u_decode (
        .pattern (cmp.seg),
        .value   (dec_value),
        .valid   (dec_valid)
    );

    assign cnt_inc = cnt + 1'b1;
    assign cap_idx = an_index(cmp.an);

    // A mismatch in SETTLE/HOLD re-runs the SCAN decision on the same sample,
    // so every dwell starts settling one cycle after it is registered.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        load_cmp = 1'b0;
        capture  = 1'b0;
        rescan   = 1'b0;
        case (state)
            SCAN:   rescan = 1'b1;
            SETTLE: begin
                if (smp != cmp) begin
                    rescan = 1'b1;
                end else if (cnt_inc >= CW'(STABLE_CYCLES - 1)) begin
                    capture  = 1'b1;
                    cnt_nx   = cnt_inc;
                    state_nx = HOLD;
                end else begin
                    cnt_nx = cnt_inc;
                end
            end
            HOLD:    if (smp != cmp) rescan = 1'b1;
            default: state_nx = SCAN;
        endcase
        if (rescan) begin
            if (an_is_select(smp.an)) begin
                load_cmp = 1'b1;
                cnt_nx   = '0;
                state_nx = SETTLE;
            end else begin
                state_nx = SCAN;
            end
        end
    end

    always_comb begin
        shadow_nx             = shadow;
        shadow_dp_nx          = shadow_dp;
        shadow_nx[cap_idx]    = dec_value;
        shadow_dp_nx[cap_idx] = ~cmp.dp;
        seen_nx               = seen | (4'b0001 << cap_idx);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            smp           <= '{an: 8'hFF, dp: 1'b1, seg: BLANK};
            cmp           <= '0;
            state         <= SCAN;
            cnt           <= '0;
            tcnt          <= '0;
            shadow        <= '0;
            shadow_dp     <= '0;
            seen          <= '0;
            digit_q       <= '0;
            dp_q          <= '0;
            frame_valid_q <= 1'b0;
            seg_err_q     <= 1'b0;
        end else begin
            smp           <= '{an: bus.AN, dp: bus.dp, seg: bus.sseg};
            state         <= state_nx;
            cnt           <= cnt_nx;
            frame_valid_q <= 1'b0;
            if (load_cmp) cmp <= smp;

            if (capture && !dec_valid) seg_err_q <= 1'b1;

            if (capture && dec_valid) begin
                shadow    <= shadow_nx;
                shadow_dp <= shadow_dp_nx;
                tcnt      <= '0;
                if (seen_nx == 4'hF) begin
                    digit_q       <= shadow_nx;
                    dp_q          <= shadow_dp_nx;
                    frame_valid_q <= 1'b1;
                    seen          <= '0;
                end else begin
                    seen <= seen_nx;
                end
            end else if (tcnt != TW'(TIMEOUT_CYCLES)) begin
                tcnt <= tcnt + 1'b1;
            end
        end
    end

    assign bus.digit0      = digit_q[0];
    assign bus.digit1      = digit_q[1];
    assign bus.digit2      = digit_q[2];
    assign bus.digit3      = digit_q[3];
    assign bus.dp_out      = dp_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.seg_err     = seg_err_q;
    assign bus.stale       = (tcnt == TW'(TIMEOUT_CYCLES));

endmodule

// File: tb/tb_sseg_scan_decoder.sv
// Scoreboard bench: a behavioural model predicts each frame when its
// completing dwell is driven; a monitor pops and compares on frame_valid.
module tb_sseg_scan_decoder;

    localparam int unsigned STABLE  = 4;
    localparam int unsigned TIMEOUT = 64;

    typedef struct {
        logic [15:0] digits;
        logic [3:0]  dps;
        int unsigned cyc;
    } exp_t;

    logic clk;
    logic reset;
    int unsigned cyc;
    int checks;
    int failures;
    int fv_count;
    int fv_before;

    exp_t exp_q[$];
    exp_t e;

    logic [3:0]  m_dig [4];
    logic [3:0]  m_dp;
    logic [3:0]  m_seen;
    logic        m_err;
    int unsigned last_cap;

    logic [6:0] tb_pat [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    sseg_scan_decoder_if bus();

    sseg_scan_decoder #(
        .STABLE_CYCLES  (STABLE),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, expv);
        end
    endtask

    function automatic bit tb_decode(input logic [6:0] p, output logic [3:0] v);
        v = '0;
        for (int i = 0; i < 16; i++) begin
            if (p == tb_pat[i]) begin
                v = 4'(i);
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    function automatic bit tb_sel(input logic [7:0] an, output int idx);
        idx = 0;
        case (an)
            8'hFE: begin idx = 0; return 1'b1; end
            8'hFD: begin idx = 1; return 1'b1; end
            8'hFB: begin idx = 2; return 1'b1; end
            8'hF7: begin idx = 3; return 1'b1; end
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 4; i++) m_dig[i] = '0;
        m_dp   = '0;
        m_seen = '0;
        m_err  = 1'b0;
    endtask

    // Hold one display state for n cycles and predict what it produces.
    task automatic dwell(input logic [7:0] an, input logic [6:0] seg, input logic dpi, input int n);
        int unsigned k;
        int idx;
        logic [3:0] v;
        @(posedge clk); #1;
        bus.AN   = an;
        bus.sseg = seg;
        bus.dp   = dpi;
        k = cyc;
        if (n >= int'(STABLE) && tb_sel(an, idx)) begin
            if (tb_decode(seg, v)) begin
                m_dig[idx]  = v;
                m_dp[idx]   = ~dpi;
                m_seen[idx] = 1'b1;
                last_cap    = k + STABLE + 1;
                if (m_seen == 4'hF) begin
                    exp_q.push_back('{digits: {m_dig[3], m_dig[2], m_dig[1], m_dig[0]},
                                      dps: m_dp, cyc: k + STABLE + 1});
                    m_seen = '0;
                end
            end else begin
                m_err = 1'b1;
            end
        end
        repeat (n - 1) @(posedge clk);
    endtask

    task automatic idle(input int n);
        dwell(8'hFF, 7'h7F, 1'b1, n);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset    = 1'b1;
        bus.AN   = 8'hFF;
        bus.sseg = 7'h7F;
        bus.dp   = 1'b1;
        model_clear();
        #1;
        check("rst_digits", {bus.digit3, bus.digit2, bus.digit1, bus.digit0}, 16'h0000);
        check("rst_dp_out", bus.dp_out, 4'h0);
        check("rst_fv", bus.frame_valid, 1'b0);
        check("rst_seg_err", bus.seg_err, 1'b0);
        check("rst_stale", bus.stale, 1'b0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!reset && bus.frame_valid) begin
            fv_count++;
            if (exp_q.size() == 0) begin
                check("unexpected_fv", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("fv_cycle", cyc, e.cyc);
                check("fv_digits", {bus.digit3, bus.digit2, bus.digit1, bus.digit0}, e.digits);
                check("fv_dp_out", bus.dp_out, e.dps);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks   = 0;
        failures = 0;
        fv_count = 0;
        last_cap = 0;
        reset    = 1'b1;
        bus.AN   = 8'hFF;
        bus.sseg = 7'h7F;
        bus.dp   = 1'b1;
        model_clear();
        do_reset();

        // Basic scan: digits 3,2,1,0.
        dwell(8'hFE, 7'h30, 1'b1, 8);
        dwell(8'hFD, 7'h24, 1'b1, 8);
        dwell(8'hFB, 7'h79, 1'b1, 8);
        dwell(8'hF7, 7'h40, 1'b1, 8);
        idle(4);
        check("scan_digits", {bus.digit3, bus.digit2, bus.digit1, bus.digit0}, 16'h0123);
        check("scan_fv_count", fv_count, 1);
        check("scan_dp_out", bus.dp_out, 4'h0);

        // Decimal point on position 3 only.
        dwell(8'hFE, 7'h06, 1'b1, 8);
        dwell(8'hFD, 7'h0E, 1'b1, 8);
        dwell(8'hFB, 7'h21, 1'b1, 8);
        dwell(8'hF7, 7'h46, 1'b0, 8);
        idle(4);
        check("dp_dp_out", bus.dp_out, 4'b1000);
        check("dp_digits", {bus.digit3, bus.digit2, bus.digit1, bus.digit0}, 16'hCDFE);

        // Glitching position 0 must not complete the frame.
        dwell(8'hFD, 7'h19, 1'b1, 8);
        dwell(8'hFB, 7'h12, 1'b1, 8);
        dwell(8'hF7, 7'h02, 1'b1, 8);
        for (int i = 0; i < 6; i++) dwell(8'hFE, (i % 2 == 0) ? 7'h40 : 7'h79, 1'b1, 2);
        idle(6);
        check("glitch_no_fv", fv_count, 2);
        dwell(8'hFE, 7'h78, 1'b1, 8);
        idle(4);
        check("glitch_recover_fv", fv_count, 3);
        check("glitch_digits", {bus.digit3, bus.digit2, bus.digit1, bus.digit0}, 16'h6547);

        // Blank on position 2: error flag, no frame until a real digit2.
        check("err_before", bus.seg_err, 1'b0);
        dwell(8'hFE, 7'h00, 1'b1, 8);
        dwell(8'hFD, 7'h10, 1'b1, 8);
        dwell(8'hFB, 7'h7F, 1'b1, 8);
        dwell(8'hF7, 7'h08, 1'b1, 8);
        idle(4);
        check("err_seg_err", bus.seg_err, m_err);
        check("err_digit2_kept", bus.digit2, 4'h5);
        check("err_fv_withheld", fv_count, 3);
        dwell(8'hFB, 7'h03, 1'b1, 8);
        idle(4);
        check("err_fv_after_fix", fv_count, 4);
        check("err_digits", {bus.digit3, bus.digit2, bus.digit1, bus.digit0}, 16'hAB98);

        // Invalid selects never capture; stale rises exactly at the timeout.
        dwell(8'hFE, 7'h40, 1'b1, 8);
        check("stale_after_cap", bus.stale, 1'b0);
        @(posedge clk); #1;
        bus.AN = 8'hFC;
        for (int i = 0; i < 200 && cyc != last_cap + TIMEOUT - 1; i++) @(negedge clk);
        check("stale_wait", cyc, last_cap + TIMEOUT - 1);
        check("stale_before_limit", bus.stale, 1'b0);
        @(negedge clk);
        check("stale_at_limit", bus.stale, 1'b1);
        dwell(8'hEE, 7'h40, 1'b1, 10);
        check("stale_ee_held", bus.stale, 1'b1);
        check("stale_no_fv", fv_count, 4);
        dwell(8'hFE, 7'h79, 1'b1, 8);
        check("stale_cleared", bus.stale, 1'b0);

        // Reset mid-frame discards partial captures.
        dwell(8'hFD, 7'h24, 1'b1, 8);
        dwell(8'hFB, 7'h30, 1'b1, 8);
        check("pre_reset_queue", exp_q.size(), 0);
        do_reset();
        fv_before = fv_count;
        dwell(8'hFE, 7'h12, 1'b1, 8);
        dwell(8'hFD, 7'h02, 1'b1, 8);
        dwell(8'hFB, 7'h78, 1'b1, 8);
        dwell(8'hF7, 7'h00, 1'b1, 8);
        idle(6);
        check("post_reset_fv", fv_count, fv_before + 1);
        check("post_reset_digits", {bus.digit3, bus.digit2, bus.digit1, bus.digit0}, 16'h8765);
        check("post_reset_seg_err", bus.seg_err, 1'b0);

        check("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
